// File: rtl/dly_pool_sched.sv
// Shared pool of NTMR programmable down-counters serving NREQ one-shot delay
// requesters with fixed-priority allocation, queuing, abort and overrun flags.
module dly_pool_sched #(
   parameter int NREQ = 4,
   parameter int NTMR = 2,
   parameter int DW   = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*DW-1:0] dly,
   input  logic [NREQ-1:0]   abort,
   input  logic              clr_ovr,
   output logic [NREQ-1:0]   done,
   output logic [NREQ-1:0]   busy,
   output logic [NREQ-1:0]   ovr
);

   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [DW-1:0]   r_cnt  [NTMR];
   logic [OW-1:0]   r_own  [NTMR];
   logic [NREQ-1:0] r_pend;
   logic [DW-1:0]   r_pdly [NREQ];
   logic [NREQ-1:0] r_done;
   logic [NREQ-1:0] r_busy;
   logic [NREQ-1:0] r_ovr;

   logic [DW-1:0]   w_cnt_n  [NTMR];
   logic [OW-1:0]   w_own_n  [NTMR];
   logic [NREQ-1:0] w_pend_n;
   logic [DW-1:0]   w_pdly_n [NREQ];
   logic [NREQ-1:0] w_done_n;
   logic [NREQ-1:0] w_busy_n;
   logic [NREQ-1:0] w_ovr_n;
   logic [NREQ-1:0] w_acc;
   logic [NREQ-1:0] w_cand;
   logic [NTMR-1:0] w_taken;
   logic [DW-1:0]   w_d;
   logic            w_found;

   always_comb begin
      w_cnt_n  = r_cnt;
      w_own_n  = r_own;
      w_pend_n = r_pend;
      w_pdly_n = r_pdly;
      w_done_n = '0;
      w_busy_n = '0;
      w_ovr_n  = clr_ovr ? '0 : r_ovr;
      w_acc    = '0;
      w_cand   = '0;
      w_taken  = '0;
      w_d      = '0;
      w_found  = 1'b0;

      // Running timers: an aborted owner kills its timer and its done pulse.
      for (int t = 0; t < NTMR; t++) begin
         if (r_cnt[t] != '0) begin
            if (abort[r_own[t]]) begin
               w_cnt_n[t] = '0;
            end else begin
               w_cnt_n[t] = r_cnt[t] - 1'b1;
               if (r_cnt[t] == DW'(1))
                  w_done_n[r_own[t]] = 1'b1;
            end
         end
      end

      // Request filtering; a set from a dropped req wins over clr_ovr.
      for (int i = 0; i < NREQ; i++) begin
         if (abort[i]) begin
            w_pend_n[i] = 1'b0;
         end else if (req[i]) begin
            if (r_busy[i]) w_ovr_n[i] = 1'b1;
            else           w_acc[i]   = 1'b1;
         end
         w_cand[i] = (r_pend[i] & ~abort[i]) | w_acc[i];
      end

      // Fixed-priority allocation: timers free only when cnt==0 at this edge.
      for (int i = 0; i < NREQ; i++) begin
         if (w_cand[i]) begin
            w_d = r_pend[i] ? r_pdly[i] : dly[i*DW +: DW];
            if (w_d == '0) w_d = DW'(1);
            w_found = 1'b0;
            for (int t = 0; t < NTMR; t++) begin
               if (!w_found && r_cnt[t] == '0 && !w_taken[t]) begin
                  w_found    = 1'b1;
                  w_taken[t] = 1'b1;
                  w_cnt_n[t] = w_d;
                  w_own_n[t] = OW'(i);
               end
            end
            w_pend_n[i] = ~w_found;
            w_pdly_n[i] = w_d;
         end
      end

      for (int i = 0; i < NREQ; i++) begin
         w_busy_n[i] = w_pend_n[i];
         for (int t = 0; t < NTMR; t++)
            if (w_cnt_n[t] != '0 && w_own_n[t] == OW'(i))
               w_busy_n[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int t = 0; t < NTMR; t++) r_cnt[t] <= '0;
         r_pend <= '0;
         r_done <= '0;
         r_busy <= '0;
         r_ovr  <= '0;
      end else begin
         r_cnt  <= w_cnt_n;
         r_pend <= w_pend_n;
         r_done <= w_done_n;
         r_busy <= w_busy_n;
         r_ovr  <= w_ovr_n;
      end
   end

   // Owner and queued-delay payloads are only meaningful alongside cnt/pend.
   always_ff @(posedge clk) begin
      r_own  <= w_own_n;
      r_pdly <= w_pdly_n;
   end

   assign done = r_done;
   assign busy = r_busy;
   assign ovr  = r_ovr;

endmodule
